ecl_xlat_sched: RTL and testbench
=================================

# ecl_xlat_sched

Scheduler that shares one 6-bit registered TTL-to-ECL translator between three TTL-side requesters and a clear source. It sits between the card's control logic and the translator part, driving the translator data bus, TCLK strobe and MR reset. It sequences each write as setup, then strobe, then hold, with cycle-programmable widths so the translator's 3.0 ns clock-to-out and 2.8 ns reset delays are met at any CLK frequency.

## Interface
Parameters (all legal range 1..15, 4-bit counters):
- SETUP_CYC, 2, cycles XD is stable before XTCLK rises
- STROBE_CYC, 2, cycles XTCLK is held high
- HOLD_CYC, 1, cycles XD is held after XTCLK falls
- MR_CYC, 3, cycles XMR is held high for a clear

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST_  in  1  asynchronous, active-low reset
- REQ  in  3  per-requester write request, level, held until ACK
- D0, D1, D2  in  6 each  requester data
- CLR_REQ  in  1  request to clear translator outputs
- ACK  out  3  one-cycle completion pulse, one-hot
- CLR_ACK  out  1  one-cycle clear-completion pulse
- XD  out  6  translator D bus
- XTCLK  out  1  translator TTL clock
- XMR  out  1  translator master reset, active-high
- GRANT  out  2  index of requester being serviced (0..2)
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, CLEAR, SETUP, STROBE, HOLD, DONE. All outputs are registered.
- Reset (RST_ low, asynchronous): state IDLE; XD=0, XTCLK=0, XMR=0, ACK=0, CLR_ACK=0, GRANT=0, BUSY=0, round-robin pointer LAST=2.
  - A reset in the middle of an operation aborts it immediately, including mid-strobe and mid-clear.
  - No ACK or CLR_ACK is issued for an aborted operation.
- IDLE, clear path: if CLR_REQ=1, enter CLEAR. Clear has priority over any REQ.
- IDLE, write path: otherwise, if any REQ bit is 1, grant the first set bit searching cyclically from LAST+1 (mod 3).
  - GRANT is loaded with the winner; XD is loaded with that requester's D.
  - Enter SETUP.
- SETUP: XD held, XTCLK=0 for SETUP_CYC cycles, then STROBE.
- STROBE: XTCLK=1 for STROBE_CYC cycles, then HOLD.
- HOLD: XTCLK=0, XD held for HOLD_CYC cycles, then DONE.
- DONE: ACK[GRANT]=1 for exactly one cycle; LAST is set to GRANT; return to IDLE.
- CLEAR: XMR=1 for MR_CYC cycles and XD is forced to 0 on entry. Then XMR=0, CLR_ACK=1 for one cycle, return to IDLE.
- Data capture and request withdrawal:
  - Requester data is captured only at grant; later changes on Dn are ignored.
  - If REQ drops after grant, the transaction still completes and ACK still pulses.
- A requester drops REQ on the edge where it sees ACK. IDLE samples REQ one cycle after DONE, so no duplicate transfer occurs.
- CLR_REQ arriving during a write is held pending (level) and is serviced at the next IDLE, ahead of any REQ.
- CLR_REQ held high across CLR_ACK starts another clear; the source drops it on CLR_ACK.
- XTCLK and XMR are never high in the same cycle.
- Round-robin is fair: with all three REQ high continuously, grant order is 0, 1, 2, 0, …

## Timing
- REQ sampled high in IDLE at edge n:
  - GRANT and XD valid and BUSY=1 from edge n+1.
  - XTCLK rises at n+1+SETUP_CYC and falls at n+1+SETUP_CYC+STROBE_CYC.
  - ACK is high for the cycle starting at n+1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
  - IDLE is re-entered one edge later.
- Write occupancy: SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles, plus one IDLE cycle between back-to-back transfers. Defaults give 6 cycles, i.e. a 7-cycle transfer period.
- CLR_REQ sampled in IDLE at edge n: XMR high over edges n+1 .. n+MR_CYC, CLR_ACK high in the following cycle.
- XD never changes while XTCLK=1 or during HOLD.

## Test plan
- Reset then single write:
  - Stimulus: release RST_, REQ=001, D0=6'h2A, defaults.
  - Response: GRANT=0, XD=2A one cycle after sampling; XTCLK high on cycles 3–4 after grant; ACK=001 on cycle 6 after sampling; BUSY low after.
- Round-robin: REQ=111 held, D0=01, D1=02, D2=04, each requester dropping REQ on its ACK → XD sequence 01, 02, 04; ACK order 001, 010, 100; 7-cycle spacing.
- Clear priority: CLR_REQ and REQ=010 asserted together in IDLE → CLEAR first with XMR high 3 cycles and XD=0, then CLR_ACK; only then GRANT=1, XD=D1.
- Clear during write: CLR_REQ rises during STROBE → write completes with ACK; CLEAR starts on the cycle after the return to IDLE; XMR and XTCLK never overlap.
- Reset mid-strobe: RST_ low while XTCLK=1 → XTCLK, XD, BUSY are 0 immediately and no ACK is issued. With REQ still high after release, the transfer restarts from requester 0 (LAST=2).
- Data stability: toggle D1 and drop REQ[1] during SETUP → XD keeps the value captured at grant; ACK[1] still pulses.

Source files
------------

// File: rtl/ecl_xlat_sched.sv
// ecl_xlat_sched
// Shares one 6-bit registered TTL-to-ECL translator between three write
// requesters and a clear source. Each write is sequenced as setup, strobe
// and hold with cycle-programmable widths. A clear pulses the translator's
// master reset. All outputs are registered.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_     in   asynchronous active-low reset
//   REQ      in   [2:0] per-requester write request (level, held until ACK)
//   D0..D2   in   [5:0] requester data, captured at grant
//   CLR_REQ  in   request to clear translator outputs (level)
//   ACK      out  [2:0] one-cycle one-hot write completion
//   CLR_ACK  out  one-cycle clear completion
//   XD       out  [5:0] translator D bus
//   XTCLK    out  translator clock
//   XMR      out  translator master reset, active-high
//   GRANT    out  [1:0] index of requester being serviced
//   BUSY     out  high in every state except IDLE
module ecl_xlat_sched #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned MR_CYC     = 3
) (
  input  logic       CLK,
  input  logic       RST_,
  input  logic [2:0] REQ,
  input  logic [5:0] D0,
  input  logic [5:0] D1,
  input  logic [5:0] D2,
  input  logic       CLR_REQ,
  output logic [2:0] ACK,
  output logic       CLR_ACK,
  output logic [5:0] XD,
  output logic       XTCLK,
  output logic       XMR,
  output logic [1:0] GRANT,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Phase counters are loaded with width-1 and count down to zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] MR_LD     = 4'(MR_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic [5:0] xd_q, xd_d;
  logic       xtclk_q, xtclk_d;
  logic       xmr_q, xmr_d;
  logic [2:0] ack_q, ack_d;
  logic       clr_ack_q, clr_ack_d;
  logic       busy_q, busy_d;

  logic [1:0] cand1, cand2, winner;
  logic [5:0] win_data;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Cyclic search starting after the last requester served.
  always_comb begin
    cand1 = rr_next(last_q);
    cand2 = rr_next(cand1);
    if (REQ[cand1])      winner = cand1;
    else if (REQ[cand2]) winner = cand2;
    else                 winner = last_q;
  end

  always_comb begin
    case (winner)
      2'd0:    win_data = D0;
      2'd1:    win_data = D1;
      default: win_data = D2;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    xd_d      = xd_q;
    xtclk_d   = xtclk_q;
    xmr_d     = xmr_q;
    ack_d     = '0;
    clr_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = CLEAR;
          cnt_d   = MR_LD;
          xmr_d   = 1'b1;
          xd_d    = '0;
        end else if (|REQ) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          grant_d = winner;
          xd_d    = win_data;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          xmr_d     = 1'b0;
          clr_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          xtclk_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          xtclk_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          ack_d   = 3'b001 << grant_q;
          last_d  = grant_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // ACK/CLR_ACK are registered on entry, so DONE only returns to IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        xtclk_d = 1'b0;
        xmr_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 2'd2;
      grant_q   <= '0;
      xd_q      <= '0;
      xtclk_q   <= 1'b0;
      xmr_q     <= 1'b0;
      ack_q     <= '0;
      clr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      xd_q      <= xd_d;
      xtclk_q   <= xtclk_d;
      xmr_q     <= xmr_d;
      ack_q     <= ack_d;
      clr_ack_q <= clr_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ACK     = ack_q;
  assign CLR_ACK = clr_ack_q;
  assign XD      = xd_q;
  assign XTCLK   = xtclk_q;
  assign XMR     = xmr_q;
  assign GRANT   = grant_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_ecl_xlat_sched.sv
// Testbench for ecl_xlat_sched: directed sequence with randomized data and
// request masks, checked against a timeline model computed from the phase
// widths and a round-robin pointer kept in the bench.
module tb_ecl_xlat_sched;

  localparam int S  = 2;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam int MR = 3;

  logic       CLK = 1'b0;
  logic       RST_;
  logic [2:0] REQ;
  logic [5:0] dv [3];
  logic       CLR_REQ;
  logic [2:0] ACK;
  logic       CLR_ACK;
  logic [5:0] XD;
  logic       XTCLK;
  logic       XMR;
  logic [1:0] GRANT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;
  int last   = 2;

  always #5 CLK = ~CLK;

  ecl_xlat_sched #(
    .SETUP_CYC(S),
    .STROBE_CYC(ST),
    .HOLD_CYC(H),
    .MR_CYC(MR)
  ) dut (
    .CLK(CLK),
    .RST_(RST_),
    .REQ(REQ),
    .D0(dv[0]),
    .D1(dv[1]),
    .D2(dv[2]),
    .CLR_REQ(CLR_REQ),
    .ACK(ACK),
    .CLR_ACK(CLR_ACK),
    .XD(XD),
    .XTCLK(XTCLK),
    .XMR(XMR),
    .GRANT(GRANT),
    .BUSY(BUSY)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r);
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = (last + i) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called during an IDLE cycle with REQ set. Cycle k counts edges after
  // the grant decision. mode: 0 plain, 1 perturb data/REQ in setup,
  // 2 raise CLR_REQ in strobe, 3 reset in strobe.
  task automatic write_check(input int mode);
    int         g;
    int         n_ack;
    logic [5:0] dexp;
    g     = pick(REQ);
    dexp  = dv[g];
    n_ack = S + ST + H + 1;
    for (int k = 1; k <= n_ack + 1; k++) begin
      tick();
      if (k <= n_ack) begin
        chk("busy", int'(BUSY), 1);
        chk("grant", int'(GRANT), g);
        chk("xd", int'(XD), int'(dexp));
        chk("xtclk", int'(XTCLK), (k > S && k <= S + ST) ? 1 : 0);
        chk("xmr_in_write", int'(XMR), 0);
        chk("ack", int'(ACK), (k == n_ack) ? (1 << g) : 0);
      end else begin
        chk("busy_idle", int'(BUSY), 0);
        chk("ack_idle", int'(ACK), 0);
        chk("xtclk_idle", int'(XTCLK), 0);
      end
      if (mode == 1 && k == 1) begin
        dv[g]  = dv[g] ^ 6'h3F;
        REQ[g] = 1'b0;
      end
      if (mode == 2 && k == S + 1) CLR_REQ = 1'b1;
      if (mode == 3 && k == S + 1) begin
        RST_ = 1'b0;
        #1;
        chk("rst_xtclk", int'(XTCLK), 0);
        chk("rst_xd", int'(XD), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_ack", int'(ACK), 0);
        chk("rst_grant", int'(GRANT), 0);
        #2;
        RST_ = 1'b1;
        last = 2;
        return;
      end
      if (k == n_ack) begin
        REQ[g] = 1'b0;
        last   = g;
      end
    end
  endtask

  // Called during an IDLE cycle with CLR_REQ high.
  task automatic clear_check(input bit hold);
    for (int k = 1; k <= MR + 2; k++) begin
      tick();
      if (k <= MR) begin
        chk("xmr", int'(XMR), 1);
        chk("xd_clear", int'(XD), 0);
        chk("xtclk_clear", int'(XTCLK), 0);
        chk("busy_clear", int'(BUSY), 1);
        chk("clr_ack_early", int'(CLR_ACK), 0);
      end else if (k == MR + 1) begin
        chk("xmr_end", int'(XMR), 0);
        chk("clr_ack", int'(CLR_ACK), 1);
        chk("ack_in_clear", int'(ACK), 0);
        if (!hold) CLR_REQ = 1'b0;
      end else begin
        chk("clr_ack_idle", int'(CLR_ACK), 0);
        chk("busy_after_clear", int'(BUSY), 0);
      end
    end
  endtask

  initial begin
    RST_    = 1'b0;
    REQ     = '0;
    CLR_REQ = 1'b0;
    for (int i = 0; i < 3; i++) dv[i] = '0;
    tick();
    tick();
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_xd", int'(XD), 0);
    chk("reset_xtclk", int'(XTCLK), 0);
    chk("reset_xmr", int'(XMR), 0);
    chk("reset_ack", int'(ACK), 0);
    chk("reset_clr_ack", int'(CLR_ACK), 0);
    chk("reset_grant", int'(GRANT), 0);
    RST_ = 1'b1;
    tick();

    // Single write from requester 0.
    REQ   = 3'b001;
    dv[0] = 6'h2A;
    write_check(0);

    // Round-robin with all three requesting.
    dv[0] = 6'h01;
    dv[1] = 6'h02;
    dv[2] = 6'h04;
    REQ   = 3'b111;
    write_check(0);
    write_check(0);
    write_check(0);

    // Clear has priority over a simultaneous request.
    dv[1]   = 6'($urandom);
    REQ     = 3'b010;
    CLR_REQ = 1'b1;
    clear_check(0);
    write_check(0);

    // Clear raised during strobe waits for the write to finish.
    REQ   = 3'b100;
    dv[2] = 6'($urandom);
    write_check(2);
    clear_check(0);

    // Clear held across CLR_ACK starts a second clear.
    CLR_REQ = 1'b1;
    clear_check(1);
    clear_check(0);

    // Data and request changes after grant are ignored.
    REQ   = 3'b010;
    dv[1] = 6'($urandom);
    write_check(1);

    // Randomized request masks and data.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 3; i++) dv[i] = 6'($urandom);
      if (REQ == 3'b000) REQ = 3'($urandom_range(1, 7));
      write_check(0);
    end

    // Reset mid-strobe, then restart from requester 0.
    REQ = 3'b000;
    tick();
    REQ   = 3'b001;
    dv[0] = 6'($urandom);
    write_check(0);
    REQ = 3'b011;
    write_check(3);
    dv[0] = 6'($urandom);
    write_check(0);
    REQ = 3'b000;
    tick();
    chk("final_busy", int'(BUSY), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
